// File: rtl/uart_result_sender_if.sv
// Signal bundle between the match controller, the result sender and the UART TX core.
// The sender uses the master view, and the controller/TX core side uses the slave view.
interface uart_result_sender_if;
    logic [1:0] UARTsend;
    logic [8:0] matchRow;
    logic       UARTsendComplete;
    logic       txBusy;
    logic       txStart;
    logic [7:0] txData;

    modport master (
        input  UARTsend, matchRow, txBusy,
        output txStart, txData, UARTsendComplete
    );

    modport slave (
        output UARTsend, matchRow, txBusy,
        input  txStart, txData, UARTsendComplete
    );
endinterface

// File: rtl/uart_result_sender.sv
// Formats one template-match result as ASCII ("M" + 3 decimal digits + LF, or "N" + LF)
// and streams it through the UART TX core under its busy handshake.
module uart_result_sender #(
    parameter logic [7:0] MATCH_CHAR   = 8'h4D,
    parameter logic [7:0] NOMATCH_CHAR = 8'h4E,
    parameter logic [7:0] TERM_CHAR    = 8'h0A
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_result_sender_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, CONV_H, CONV_T, SEND, WAIT_BUSY, WAIT_IDLE, DONE, HOLD
    } state_t;

    state_t     state;
    logic       is_match;
    logic [8:0] rem;
    logic [2:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
    logic [2:0] idx;
    logic [2:0] last_idx;
    logic [7:0] cur_byte;

    always_comb begin
        cur_byte = TERM_CHAR;
        if (is_match) begin
            case (idx)
                3'd0:    cur_byte = MATCH_CHAR;
                3'd1:    cur_byte = 8'h30 + {5'd0, hund};
                3'd2:    cur_byte = 8'h30 + {4'd0, tens};
                3'd3:    cur_byte = 8'h30 + {4'd0, units};
                default: cur_byte = TERM_CHAR;
            endcase
        end else if (idx == 3'd0) begin
            cur_byte = NOMATCH_CHAR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            is_match             <= 1'b0;
            rem                  <= '0;
            hund                 <= '0;
            tens                 <= '0;
            units                <= '0;
            idx                  <= '0;
            last_idx             <= '0;
            bus.txStart          <= 1'b0;
            bus.txData           <= '0;
            bus.UARTsendComplete <= 1'b0;
        end else begin
            bus.txStart          <= 1'b0;
            bus.UARTsendComplete <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.UARTsend == 2'd1 || bus.UARTsend == 2'd2) begin
                        is_match <= (bus.UARTsend == 2'd1);
                        rem      <= bus.matchRow;
                        hund     <= '0;
                        tens     <= '0;
                        units    <= '0;
                        idx      <= '0;
                        if (bus.UARTsend == 2'd1) begin
                            state <= CONV_H;
                        end else begin
                            last_idx <= 3'd1;
                            state    <= SEND;
                        end
                    end
                end
                // Binary-to-decimal by repeated subtraction, one step per cycle.
                CONV_H: begin
                    if (rem >= 9'd100) begin
                        rem  <= rem - 9'd100;
                        hund <= hund + 3'd1;
                    end else begin
                        state <= CONV_T;
                    end
                end
                CONV_T: begin
                    if (rem >= 9'd10) begin
                        rem  <= rem - 9'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        units    <= rem[3:0];
                        last_idx <= 3'd4;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (!bus.txBusy) begin
                        bus.txStart <= 1'b1;
                        bus.txData  <= cur_byte;
                        state       <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (bus.txBusy) state <= WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (!bus.txBusy) begin
                        if (idx == last_idx) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SEND;
                        end
                    end
                end
                DONE: begin
                    bus.UARTsendComplete <= 1'b1;
                    state                <= HOLD;
                end
                // Requester keeps UARTsend asserted after completion; wait for it to drop.
                HOLD: begin
                    if (bus.UARTsend == 2'd0 || bus.UARTsend == 2'd3) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_result_sender.sv
// Directed bench for uart_result_sender with a simple busy-counting UART TX model.
module tb_uart_result_sender;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    uart_result_sender_if bus();

    uart_result_sender #(
        .MATCH_CHAR  (8'h4D),
        .NOMATCH_CHAR(8'h4E),
        .TERM_CHAR   (8'h0A)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] cap[$];
    int         ncomplete = 0;
    int         ndouble = 0;
    int         busy_cnt = 0;
    int         busy_len = 10;
    logic       force_busy = 1'b0;
    logic       prev_start = 1'b0;

    assign bus.txBusy = (busy_cnt > 0) || force_busy;

    // TX model and monitor: busy for busy_len cycles after each accepted byte.
    always @(negedge clock) begin
        if (bus.txStart === 1'b1) begin
            cap.push_back(bus.txData);
            if (prev_start) ndouble++;
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        if (bus.UARTsendComplete === 1'b1) ncomplete++;
        prev_start = bus.txStart;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic [1:0] code, input logic [8:0] row);
        cap.delete();
        ncomplete = 0;
        ndouble   = 0;
        bus.UARTsend = code;
        bus.matchRow = row;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (ncomplete == 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (ncomplete == 0) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_msg(input string tag, input logic [39:0] exp, input int n);
        logic [39:0] e;
        e = exp;
        chk({tag, "_len"}, cap.size(), n);
        for (int i = 0; i < n && i < cap.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), {24'd0, cap[i]}, {24'd0, e[8*(n-1-i) +: 8]});
        chk({tag, "_cmpl"}, ncomplete, 1);
        chk({tag, "_dbl"}, ndouble, 0);
    endtask

    task automatic release_req();
        repeat (3) @(negedge clock);
        bus.UARTsend = 2'd0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int n;
        bus.UARTsend = 2'd0;
        bus.matchRow = 9'd0;
        repeat (3) @(negedge clock);
        chk("rst_start", bus.txStart, 0);
        chk("rst_data", bus.txData, 8'h00);
        chk("rst_cmpl", bus.UARTsendComplete, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        start_req(2'd1, 9'd379);
        wait_done("m379");
        check_msg("m379", 40'h4D3337390A, 5);
        chk("m379_hold_data", bus.txData, 8'h0A);
        release_req();

        start_req(2'd1, 9'd0);
        wait_done("m0");
        check_msg("m0", 40'h4D3030300A, 5);
        release_req();

        start_req(2'd1, 9'd511);
        wait_done("m511");
        check_msg("m511", 40'h4D3531310A, 5);
        release_req();

        start_req(2'd2, 9'd77);
        wait_done("nm");
        check_msg("nm", 40'h0000004E0A, 2);
        release_req();

        // Core busy at request time, and row changed mid-conversion.
        force_busy = 1'b1;
        start_req(2'd1, 9'd379);
        repeat (3) @(negedge clock);
        bus.matchRow = 9'd123;
        repeat (17) @(negedge clock);
        chk("busy_nostart", cap.size(), 0);
        force_busy = 1'b0;
        wait_done("busy");
        check_msg("busy", 40'h4D3337390A, 5);

        // Request held long after completion: no repeat message.
        repeat (50) @(negedge clock);
        chk("hold_nobytes", cap.size(), 5);
        chk("hold_ncmpl", ncomplete, 1);
        bus.UARTsend = 2'd0;
        repeat (2) @(negedge clock);
        start_req(2'd2, 9'd5);
        wait_done("nm2");
        check_msg("nm2", 40'h0000004E0A, 2);
        release_req();

        // Reset during byte 2 of a match message.
        start_req(2'd1, 9'd250);
        n = 0;
        while (cap.size() < 2 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (cap.size() < 2) chk("rst_mid_timeout", 0, 1);
        reset = 1'b1;
        bus.UARTsend = 2'd0;
        @(negedge clock);
        chk("rstmid_start", bus.txStart, 0);
        chk("rstmid_cmpl", bus.UARTsendComplete, 0);
        chk("rstmid_data", bus.txData, 8'h00);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        start_req(2'd1, 9'd42);
        wait_done("after_rst");
        check_msg("after_rst", 40'h4D3034320A, 5);
        release_req();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_result_sender.md
Name: uart_result_sender

Overview:
Sequences the UART transmitter to report the result of one template-match run. Sits between the match control unit and the UART TX core. On a MATCH/NOT_MATCH request it formats an ASCII message (row number converted to decimal), streams it byte-by-byte under the TX busy handshake, then pulses UARTsendComplete so the control unit can return to idle.

Parameters:
MATCH_CHAR, 8'h4D, first byte of a match message ('M')
NOMATCH_CHAR, 8'h4E, first byte of a no-match message ('N')
TERM_CHAR, 8'h0A, message terminator (LF)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
UARTsend  input  2  request code: 0 OFF, 1 MATCH, 2 NOT_MATCH, 3 treated as OFF
matchRow  input  9  image row of the match (0..511), sampled only at request accept
txBusy  input  1  UART TX core busy; high while a byte is shifting out
txStart  output  1  one-cycle pulse: load txData into UART TX core
txData  output  8  byte to transmit; valid in the txStart cycle
UARTsendComplete  output  1  one-cycle pulse after last byte has left the TX core

Behaviour:
- Reset values: txStart=0, txData=8'h00, UARTsendComplete=0, state=IDLE, all internal counters 0. Reset mid-message aborts immediately to IDLE; a byte already inside the TX core is not recalled.
- States: IDLE, CONV_H, CONV_T, SEND, WAIT_BUSY, WAIT_IDLE, DONE, HOLD.
- IDLE: when UARTsend is 1 or 2, latch code and matchRow into internal registers; code 1 -> CONV_H, code 2 -> SEND with message length 2. Later changes to matchRow/UARTsend are ignored until HOLD.
- Decimal conversion by repeated subtraction, one subtraction per cycle:
  - CONV_H: if rem >= 100 then rem -= 100, hund += 1, stay; else -> CONV_T.
  - CONV_T: if rem >= 10 then rem -= 10, tens += 1, stay; else units = rem, -> SEND with message length 5.
  - Widths: rem 9 bits, hund 3 bits (max 5), tens 4 bits (max 9), units 4 bits. Row 379 converts in 3+7+2 cycles; row 0 in 2 cycles.
- Message bytes by index: MATCH: 0 MATCH_CHAR, 1 8'h30+hund, 2 8'h30+tens, 3 8'h30+units, 4 TERM_CHAR. NOT_MATCH: 0 NOMATCH_CHAR, 1 TERM_CHAR. Byte index 3 bits, starts at 0.
- SEND: if txBusy=0, register txStart=1 and txData=byte[index] for exactly one cycle, -> WAIT_BUSY; if txBusy=1, hold txStart=0 and stay (no byte issued while core busy).
- WAIT_BUSY: wait for txBusy=1 (accepts any number of cycles of TX start latency), -> WAIT_IDLE.
- WAIT_IDLE: wait for txBusy=0; then if index is last -> DONE, else index += 1 -> SEND.
- txData holds its last value outside the txStart cycle; txStart never high two consecutive cycles.
- DONE: UARTsendComplete=1 for exactly one cycle, -> HOLD.
- HOLD: stay until UARTsend is 0 or 3, then -> IDLE. Guarantees exactly one message per request even though the requester keeps UARTsend asserted for several cycles after the completion pulse.
- No timeout: a TX core that never raises txBusy stalls in WAIT_BUSY until reset.

Test Plan:
- UARTsend=1, matchRow=379, TX model busy 10 cycles per byte -> txData sequence 4D,33,37,39,0A, five txStart pulses, then one UARTsendComplete pulse.
- UARTsend=1, matchRow=0 -> 4D,30,30,30,0A; matchRow=511 -> 4D,35,31,31,0A.
- UARTsend=2 -> exactly 4E,0A then one UARTsendComplete pulse; matchRow value irrelevant.
- txBusy held high 20 cycles at request time -> no txStart until txBusy falls, then first byte issued; matchRow changed during conversion -> output digits unchanged.
- UARTsend held at 1 for 50 cycles after UARTsendComplete -> no second message; UARTsend drop to 0 then back to 2 -> new 4E,0A message.
- Reset asserted during byte 2 of a MATCH message -> next cycle txStart=0, UARTsendComplete=0, state IDLE; fresh request afterwards produces full correct message.
